interface_demux: RTL



---
 rtl/interface_demux_pkg.sv | 34 +++
 rtl/ifdemux_room_chk.sv | 38 +++
 rtl/interface_demux.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/interface_demux_pkg.sv
// rtl/interface_demux_pkg.sv - shared types and constants for the egress distributor
//
// Purpose: FSM state encoding, descriptor field positions and frame length
//          limits shared by interface_demux and ifdemux_room_chk.
// Ports:   none (package).
package interface_demux_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RDPTR,
    S_LAT,
    S_CHK,
    S_WAIT,
    S_DATA,
    S_FLUSH,
    S_PTRWR,
    S_DROP
  } ifdemux_state_t;

  // Descriptor layout: {mask[3:0], 1'b0, len[10:0]}
  localparam int DESC_MASK_HI = 15;
  localparam int DESC_MASK_LO = 12;
  localparam int DESC_LEN_HI  = 10;
  localparam int DESC_LEN_LO  = 0;
  localparam int LEN_W        = DESC_LEN_HI - DESC_LEN_LO + 1;

  localparam int IFDEMUX_MIN_LEN = 60;
  localparam int IFDEMUX_MAX_LEN = 1518;

  function automatic logic len_in_range(input logic [LEN_W-1:0] len);
    return (len >= LEN_W'(IFDEMUX_MIN_LEN)) && (len <= LEN_W'(IFDEMUX_MAX_LEN));
  endfunction

endpackage

// File: rtl/ifdemux_room_chk.sv
// rtl/ifdemux_room_chk.sv - per-port room check for one MAC tx FIFO pair
//
// Purpose: decides whether one port can accept a whole frame right now.
// Ports:   cnt      - data FIFO occupancy (bytes)
//          len      - frame length (bytes)
//          ptr_full - pointer FIFO full
//          sel      - port selected by the descriptor mask
//          ok       - 1 when unselected, or when both FIFOs can take the frame
module ifdemux_room_chk
  import interface_demux_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter int CNT_WIDTH = 13
) (
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic [LEN_W-1:0]     len,
  input  logic                 ptr_full,
  input  logic                 sel,
  output logic                 ok
);

  localparam int RW = CNT_WIDTH + 1;

  logic [RW-1:0] depth_w;
  logic [RW-1:0] cnt_w;
  logic [RW-1:0] len_w;
  logic [RW-1:0] room;
  logic          fits;

  assign depth_w = RW'(DEPTH);
  assign cnt_w   = {1'b0, cnt};
  assign len_w   = RW'(len);
  assign room    = depth_w - cnt_w;
  // An over-full count would wrap room to a huge value, so it is rejected first.
  assign fits    = (cnt_w <= depth_w) && (room >= len_w);
  assign ok      = !sel || (fits && !ptr_full);

endmodule

// File: rtl/interface_demux.sv
// rtl/interface_demux.sv - egress distributor replicating frames into four MAC tx FIFOs
//
// Purpose: pops a descriptor and its payload from the backend FIFO pair and
//          writes the frame into every tx FIFO selected by the 4-bit mask,
//          followed by one length pointer per selected port. Bad frames are
//          read out and discarded.
// Option:  IFDEMUX_LEN_CHK_EN - when defined, lengths outside 60..1518 are dropped.
// Ports:   clk_sys, rstn_sys                  - clock, sync active-low reset
//          sfifo_rd / sfifo_dout              - backend data FIFO read / byte
//          ptr_sfifo_rd / _dout / _empty      - backend descriptor FIFO
//          tx_data_fifo_din, _wr0..3, _cnt0..3 - tx data FIFOs (shared byte)
//          tx_ptr_fifo_din, _wr0..3, _full0..3 - tx pointer FIFOs (shared length)
//          ifdemux_drop                       - one pulse per discarded frame
module interface_demux
  import interface_demux_pkg::*;
#(
  parameter int TX_FIFO_DEPTH = 4096,
  parameter int TX_CNT_WIDTH  = 13
) (
  input  logic                    clk_sys,
  input  logic                    rstn_sys,
  output logic                    sfifo_rd,
  input  logic [7:0]              sfifo_dout,
  output logic                    ptr_sfifo_rd,
  input  logic [15:0]             ptr_sfifo_dout,
  input  logic                    ptr_sfifo_empty,
  output logic [7:0]              tx_data_fifo_din,
  output logic                    tx_data_fifo_wr0,
  output logic                    tx_data_fifo_wr1,
  output logic                    tx_data_fifo_wr2,
  output logic                    tx_data_fifo_wr3,
  input  logic [TX_CNT_WIDTH-1:0] tx_data_fifo_cnt0,
  input  logic [TX_CNT_WIDTH-1:0] tx_data_fifo_cnt1,
  input  logic [TX_CNT_WIDTH-1:0] tx_data_fifo_cnt2,
  input  logic [TX_CNT_WIDTH-1:0] tx_data_fifo_cnt3,
  output logic [15:0]             tx_ptr_fifo_din,
  output logic                    tx_ptr_fifo_wr0,
  output logic                    tx_ptr_fifo_wr1,
  output logic                    tx_ptr_fifo_wr2,
  output logic                    tx_ptr_fifo_wr3,
  input  logic                    tx_ptr_fifo_full0,
  input  logic                    tx_ptr_fifo_full1,
  input  logic                    tx_ptr_fifo_full2,
  input  logic                    tx_ptr_fifo_full3,
  output logic                    ifdemux_drop
);

  ifdemux_state_t    state;
  logic [3:0]        mask;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  xfer_cnt;
  logic              flush_cnt;
  logic              rd_fwd_d1;
  logic [3:0]        data_wr;
  logic [3:0]        ptr_wr;
  logic [3:0]        room_ok;
  logic              frame_bad;
  logic              unused_desc_bit;

  logic [TX_CNT_WIDTH-1:0] cnt_a [4];
  logic [3:0]              full_a;

  assign unused_desc_bit = ptr_sfifo_dout[11];

  assign cnt_a[0] = tx_data_fifo_cnt0;
  assign cnt_a[1] = tx_data_fifo_cnt1;
  assign cnt_a[2] = tx_data_fifo_cnt2;
  assign cnt_a[3] = tx_data_fifo_cnt3;
  assign full_a   = {tx_ptr_fifo_full3, tx_ptr_fifo_full2, tx_ptr_fifo_full1, tx_ptr_fifo_full0};

  for (genvar p = 0; p < 4; p++) begin : g_room
    ifdemux_room_chk #(
      .DEPTH     (TX_FIFO_DEPTH),
      .CNT_WIDTH (TX_CNT_WIDTH)
    ) u_room_chk (
      .cnt      (cnt_a[p]),
      .len      (len),
      .ptr_full (full_a[p]),
      .sel      (mask[p]),
      .ok       (room_ok[p])
    );
  end

`ifdef IFDEMUX_LEN_CHK_EN
  assign frame_bad = (mask == 4'd0) || (len == '0) || !len_in_range(len);
`else
  assign frame_bad = (mask == 4'd0) || (len == '0);
`endif

  assign {tx_data_fifo_wr3, tx_data_fifo_wr2, tx_data_fifo_wr1, tx_data_fifo_wr0} = data_wr;
  assign {tx_ptr_fifo_wr3, tx_ptr_fifo_wr2, tx_ptr_fifo_wr1, tx_ptr_fifo_wr0}     = ptr_wr;

  always_ff @(posedge clk_sys) begin
    if (!rstn_sys) begin
      state            <= S_IDLE;
      mask             <= '0;
      len              <= '0;
      xfer_cnt         <= '0;
      flush_cnt        <= 1'b0;
      rd_fwd_d1        <= 1'b0;
      data_wr          <= '0;
      ptr_wr           <= '0;
      sfifo_rd         <= 1'b0;
      ptr_sfifo_rd     <= 1'b0;
      tx_data_fifo_din <= '0;
      tx_ptr_fifo_din  <= '0;
      ifdemux_drop     <= 1'b0;
    end else begin
      ptr_sfifo_rd     <= 1'b0;
      ifdemux_drop     <= 1'b0;
      ptr_wr           <= '0;
      // Byte arrives the cycle after the read and is registered once more,
      // so strobes trail sfifo_rd by two cycles. Reads made in DROP never qualify.
      rd_fwd_d1        <= sfifo_rd && (state == S_DATA);
      data_wr          <= rd_fwd_d1 ? mask : 4'd0;
      tx_data_fifo_din <= sfifo_dout;

      case (state)
        S_IDLE: begin
          if (!ptr_sfifo_empty) begin
            ptr_sfifo_rd <= 1'b1;
            state        <= S_RDPTR;
          end
        end
        S_RDPTR: state <= S_LAT;
        S_LAT: begin
          mask  <= ptr_sfifo_dout[DESC_MASK_HI:DESC_MASK_LO];
          len   <= ptr_sfifo_dout[DESC_LEN_HI:DESC_LEN_LO];
          state <= S_CHK;
        end
        S_CHK: begin
          xfer_cnt <= LEN_W'(1);
          if (frame_bad) begin
            state        <= S_DROP;
            ifdemux_drop <= 1'b1;
            sfifo_rd     <= (len != '0);
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Whole-frame room is confirmed up front so DATA never stalls.
          if (&room_ok) begin
            state     <= S_DATA;
            sfifo_rd  <= 1'b1;
            flush_cnt <= 1'b0;
          end
        end
        S_DATA: begin
          if (xfer_cnt == len) begin
            sfifo_rd <= 1'b0;
            state    <= S_FLUSH;
          end else begin
            xfer_cnt <= xfer_cnt + LEN_W'(1);
          end
        end
        S_FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            state           <= S_PTRWR;
            ptr_wr          <= mask;
            tx_ptr_fifo_din <= {5'b0, len};
          end
        end
        S_PTRWR: state <= S_IDLE;
        S_DROP: begin
          if ((len == '0) || (xfer_cnt == len)) begin
            sfifo_rd <= 1'b0;
            state    <= S_IDLE;
          end else begin
            xfer_cnt <= xfer_cnt + LEN_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
